// File: rtl/apb_mtimer.sv
// apb_mtimer: RISC-V machine timer (mtime/mtimecmp) exposed as a zero-wait-state APB completer.
// A prescaled 64-bit counter drives a registered level interrupt when mtime >= mtimecmp.
module apb_mtimer #(
  parameter int AddrWidth   = 12,
  parameter int PrescWidth  = 8,
  parameter bit ResetEnable = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [31:0]          pwdata_i,
  input  logic [3:0]           pstrb_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 irq_o
);

  localparam logic [2:0] OffMtimeLo = 3'd0;
  localparam logic [2:0] OffMtimeHi = 3'd1;
  localparam logic [2:0] OffCmpLo   = 3'd2;
  localparam logic [2:0] OffCmpHi   = 3'd3;
  localparam logic [2:0] OffCtrl    = 3'd4;

  logic [63:0]           r_mtime;
  logic [63:0]           r_cmp;
  logic [31:0]           r_shadow;
  logic [PrescWidth-1:0] r_presc;
  logic [PrescWidth-1:0] r_cnt;
  logic                  r_en;
  logic                  r_irq;

  logic                  w_access;
  logic                  w_err;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_ctrl_wr;
  logic                  w_tick;
  logic [2:0]            w_off;
  logic [63:0]           w_mtime_nxt;
  logic [63:0]           w_cmp_nxt;
  logic [31:0]           w_shadow_nxt;
  logic [31:0]           w_ctrl;
  logic [PrescWidth-1:0] w_presc_nxt;
  logic [PrescWidth-1:0] w_cnt_nxt;
  logic                  w_en_nxt;
  logic                  w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign w_unused = ^{paddr_i[AddrWidth-1:5], paddr_i[1:0]};

  always_comb begin
    w_access  = psel_i & penable_i;
    w_off     = paddr_i[4:2];
    w_err     = w_access & (w_off > OffCtrl);
    w_wr      = w_access & pwrite_i & ~w_err;
    w_rd      = w_access & ~pwrite_i & ~w_err;
    w_ctrl_wr = w_wr & (w_off == OffCtrl);
    w_tick    = r_en & (r_cnt == r_presc);

    // Software writes override only their own lanes of the already-ticked value.
    w_mtime_nxt = w_tick ? r_mtime + 64'd1 : r_mtime;
    if (w_wr && w_off == OffMtimeLo) w_mtime_nxt[31:0]  = f_merge(w_mtime_nxt[31:0], pwdata_i, pstrb_i);
    if (w_wr && w_off == OffMtimeHi) w_mtime_nxt[63:32] = f_merge(w_mtime_nxt[63:32], pwdata_i, pstrb_i);

    w_cmp_nxt = r_cmp;
    if (w_wr && w_off == OffCmpLo) w_cmp_nxt[31:0]  = f_merge(r_cmp[31:0], pwdata_i, pstrb_i);
    if (w_wr && w_off == OffCmpHi) w_cmp_nxt[63:32] = f_merge(r_cmp[63:32], pwdata_i, pstrb_i);

    w_cnt_nxt = r_cnt;
    if (r_en) w_cnt_nxt = w_tick ? '0 : r_cnt + PrescWidth'(1);
    w_presc_nxt = r_presc;
    w_en_nxt    = r_en;
    if (w_ctrl_wr && pstrb_i[0]) w_en_nxt = pwdata_i[0];
    if (w_ctrl_wr && pstrb_i[1]) begin
      w_presc_nxt = pwdata_i[8 +: PrescWidth];
      w_cnt_nxt   = '0;
    end

    // Shadow gives an atomic LO-then-HI read of the running counter.
    w_shadow_nxt = r_shadow;
    if (w_rd && w_off == OffMtimeLo) w_shadow_nxt = r_mtime[63:32];
    if (w_wr && w_off == OffMtimeHi) w_shadow_nxt = w_mtime_nxt[63:32];

    w_ctrl                   = '0;
    w_ctrl[0]                = r_en;
    w_ctrl[8 +: PrescWidth]  = r_presc;
  end

  always_comb begin
    prdata_o = '0;
    if (w_rd && !rst_i) begin
      case (w_off)
        OffMtimeLo: prdata_o = r_mtime[31:0];
        OffMtimeHi: prdata_o = r_shadow;
        OffCmpLo:   prdata_o = r_cmp[31:0];
        OffCmpHi:   prdata_o = r_cmp[63:32];
        OffCtrl:    prdata_o = w_ctrl;
        default:    prdata_o = '0;
      endcase
    end
  end

  assign pready_o  = w_access & ~rst_i;
  assign pslverr_o = w_err & ~rst_i;
  assign irq_o     = r_irq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtime  <= '0;
      r_cmp    <= '1;
      r_shadow <= '0;
      r_presc  <= '0;
      r_cnt    <= '0;
      r_en     <= ResetEnable;
      r_irq    <= 1'b0;
    end else begin
      r_mtime  <= w_mtime_nxt;
      r_cmp    <= w_cmp_nxt;
      r_shadow <= w_shadow_nxt;
      r_presc  <= w_presc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_en     <= w_en_nxt;
      r_irq    <= (w_mtime_nxt >= w_cmp_nxt);
    end
  end

endmodule

// File: tb/tb_apb_mtimer.sv
// Testbench for apb_mtimer: directed plus randomized APB traffic checked against
// an arithmetic model (mtime = base + elapsed_cycles / (PRESC+1)).
module tb_apb_mtimer;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [63:0] m_base;
  logic [63:0] m_cmp;
  int          m_anchor;
  logic        m_en;
  logic [7:0]  m_presc;
  logic [31:0] m_shadow;

  apb_mtimer dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .pstrb_i   (pstrb),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mtime as seen after the edge that brought cyc to value c
  function automatic logic [63:0] model_at(input int c);
    if (!m_en) return m_base;
    return m_base + 64'((c - m_anchor) / (int'(m_presc) + 1));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_base   = '0;
    m_cmp    = '1;
    m_anchor = cyc;
    m_en     = 1'b0;
    m_presc  = '0;
    m_shadow = '0;
  endtask

  task automatic apb(input logic wr, input logic [2:0] off, input logic [31:0] wd, input logic [3:0] strb,
                     output logic [31:0] rd, output logic err, output logic rdy,
                     output int s_cyc, output int e_cyc);
    @(posedge clk); #1;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = {7'($urandom), off, 2'($urandom)};
    pwdata  = wd;
    pstrb   = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    rd    = prdata;
    err   = pslverr;
    rdy   = pready;
    s_cyc = cyc;
    @(posedge clk); #1;
    e_cyc   = cyc;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] off);
    logic [31:0] rd, exp;
    logic        err, rdy;
    int          s, e;
    logic [63:0] mt;
    apb(1'b0, off, $urandom, 4'hF, rd, err, rdy, s, e);
    mt = model_at(s);
    case (off)
      3'd0:    exp = mt[31:0];
      3'd1:    exp = m_shadow;
      3'd2:    exp = m_cmp[31:0];
      3'd3:    exp = m_cmp[63:32];
      3'd4:    exp = {16'h0, m_presc, 7'h0, m_en};
      default: exp = 32'h0;
    endcase
    chk($sformatf("rd%0d_data", off), 64'(rd), 64'(exp));
    chk($sformatf("rd%0d_pslverr", off), 64'(err), 64'(off > 3'd4));
    chk($sformatf("rd%0d_pready", off), 64'(rdy), 64'd1);
    if (off == 3'd0) m_shadow = mt[63:32];
  endtask

  task automatic do_write(input logic [2:0] off, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] rd;
    logic        err, rdy;
    int          s, e;
    logic [63:0] nv;
    apb(1'b1, off, wd, strb, rd, err, rdy, s, e);
    nv = model_at(e);
    case (off)
      3'd0: begin nv[31:0] = merge(nv[31:0], wd, strb); m_base = nv; m_anchor = e; end
      3'd1: begin nv[63:32] = merge(nv[63:32], wd, strb); m_base = nv; m_anchor = e; m_shadow = nv[63:32]; end
      3'd2: m_cmp[31:0]  = merge(m_cmp[31:0], wd, strb);
      3'd3: m_cmp[63:32] = merge(m_cmp[63:32], wd, strb);
      3'd4: begin
        m_base = nv; m_anchor = e;
        if (strb[0]) m_en = wd[0];
        if (strb[1]) m_presc = wd[15:8];
      end
      default: ;
    endcase
    chk($sformatf("wr%0d_pslverr", off), 64'(err), 64'(off > 3'd4));
    chk($sformatf("wr%0d_pready", off), 64'(rdy), 64'd1);
    chk($sformatf("wr%0d_irq", off), 64'(irq), 64'(model_at(cyc) >= m_cmp));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_irq", 64'(irq), 64'(model_at(cyc) >= m_cmp));
      chk("idle_prdata", 64'(prdata), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] rnd;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    model_reset();
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_pslverr", 64'(pslverr), 64'd0);
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_prdata", 64'(prdata), 64'd0);
    for (int i = 0; i < 5; i++) do_read(3'(i));

    // Prescaler 3: 40 cycles -> 10 ticks, then freeze
    do_write(3'd4, 32'h0000_0301, 4'hF);
    do_read(3'd0);
    idle(35);
    do_read(3'd0);
    do_write(3'd4, 32'h0000_0300, 4'hF);
    do_read(3'd0);
    idle(8);
    do_read(3'd0);

    // Shadowed 64-bit read across a low-word carry
    do_write(3'd0, 32'hFFFF_FFFD, 4'hF);
    do_write(3'd1, 32'h0, 4'hF);
    do_write(3'd4, 32'h0000_0001, 4'hF);
    do_read(3'd0);
    do_read(3'd1);
    do_read(3'd0);
    do_read(3'd1);

    // Full 64-bit wrap
    do_write(3'd4, 32'h0, 4'hF);
    do_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    do_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    idle(2);
    do_write(3'd4, 32'h0000_0001, 4'hF);
    idle(3);
    do_read(3'd0);
    do_read(3'd1);

    // Interrupt edge and clear by raising mtimecmp
    do_write(3'd4, 32'h0, 4'hF);
    do_write(3'd2, 32'h0000_0020, 4'hF);
    do_write(3'd3, 32'h0, 4'hF);
    do_write(3'd0, 32'h0000_001E, 4'hF);
    do_write(3'd1, 32'h0, 4'hF);
    do_write(3'd4, 32'h0000_0001, 4'hF);
    idle(6);
    do_write(3'd3, 32'h0000_0001, 4'hF);
    idle(2);

    // Byte-lane write into the running counter, unmapped accesses
    do_write(3'd0, 32'h0000_AB00, 4'b0010);
    do_read(3'd0);
    do_read(3'd5);
    do_write(3'd6, 32'hDEAD_BEEF, 4'hF);
    do_read(3'd2);
    do_read(3'd3);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0, 1: do_read(3'($urandom_range(0, 7)));
        2:    do_write(3'($urandom_range(2, 3)), $urandom, 4'($urandom_range(0, 15)));
        3: begin
          rnd = $urandom;
          rnd[15:8] = 8'($urandom_range(0, 3));
          do_write(3'd4, rnd, 4'hF);
        end
        4: begin
          if (!m_en || m_presc == 8'd0)
            do_write(3'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
          else
            do_read(3'd0);
        end
        default: idle($urandom_range(1, 6));
      endcase
    end

    // Reset during the access phase of a CTRL write
    do_write(3'd4, 32'h0000_0001, 4'hF);
    idle(3);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0000_0501; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("abort_irq", 64'(irq), 64'd0);
    do_read(3'd4);
    do_read(3'd0);
    do_read(3'd1);
    idle(4);
    do_read(3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
